// File: rtl/unit_pkt_serializer.sv
// unit_pkt_serializer
//   Takes one packet descriptor at a time and turns it into the word stream that
//   a sha512unit-style computing unit expects on its input port.
//   - Data packet: header word, body, trailer word.
//   - Init packet: one control word carrying the program select.
//   Body bytes are packed W = OUT_WIDTH/8 per word, byte 0 of each word in
//   bits [7:0]. Key bytes at or beyond the clamped key length go out as zero.
//   With KEY_TRIM=1 the key section is cut down to the clamped length rounded
//   up to a multiple of 4 bytes.
//
// Ports
//   CLK, RESET_N        clock, asynchronous active-low reset
//   req_valid/req_ready descriptor handshake (ready only while idle)
//   req_type            0 = data packet, 1 = init packet
//   init_data           init payload (program select)
//   cnt, salt_len, salt, ids, key_len, key   data packet fields
//   unit_in, unit_in_ctrl, unit_in_wr_en     word stream to the unit
//   unit_in_afull       stall; no word is written after an edge where it is high
//   unit_in_ready       unit has an idle thread (checked once, before the header)
//   busy                packet in progress
module unit_pkt_serializer #(
    parameter int OUT_WIDTH     = 8,
    parameter int KEY_MAX_BYTES = 64,
    parameter int KEY_TRIM      = 0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_type,
    input  logic [4:0]                 init_data,
    input  logic [31:0]                cnt,
    input  logic [7:0]                 salt_len,
    input  logic [127:0]               salt,
    input  logic [63:0]                ids,
    input  logic [7:0]                 key_len,
    input  logic [KEY_MAX_BYTES*8-1:0] key,
    output logic [OUT_WIDTH-1:0]       unit_in,
    output logic                       unit_in_ctrl,
    output logic                       unit_in_wr_en,
    input  logic                       unit_in_afull,
    input  logic                       unit_in_ready,
    output logic                       busy
);

    localparam int W        = OUT_WIDTH / 8;
    localparam int BODY_MAX = 40 + KEY_MAX_BYTES;
    localparam int PW       = $clog2(BODY_MAX + 1);
    localparam int IW       = $clog2(BODY_MAX);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_HDR     = 3'd2;
    localparam logic [2:0] S_BODY    = 3'd3;
    localparam logic [2:0] S_TRAILER = 3'd4;
    localparam logic [2:0] S_INIT    = 3'd5;

    logic [2:0]                 state, state_d;
    logic [PW-1:0]              ptr, ptr_nxt, body_len, len_d;
    logic [BODY_MAX-1:0][7:0]   body_q, img;
    logic [4:0]                 init_q;
    logic [OUT_WIDTH-1:0]       word;
    int                         kc, kpad;

    // The whole body is laid out as a byte image at acceptance time, so the
    // emit side is just a W-byte window sliding over it.
    always_comb begin
        kc    = (int'(key_len) > KEY_MAX_BYTES) ? KEY_MAX_BYTES : int'(key_len);
        kpad  = (kc + 3) & ~3;
        len_d = (KEY_TRIM != 0) ? PW'(40 + kpad) : PW'(BODY_MAX);
        img   = '0;
        for (int b = 0; b < 4; b++)  img[b]      = cnt[b*8+:8];
        img[4] = salt_len;
        for (int b = 0; b < 16; b++) img[8+b]    = salt[b*8+:8];
        for (int b = 0; b < 8; b++)  img[24+b]   = ids[b*8+:8];
        img[32] = key_len;
        // key_len itself goes out unclamped; only the key bytes are masked
        for (int b = 0; b < KEY_MAX_BYTES; b++)
            img[40+b] = (b < kc) ? key[b*8+:8] : 8'h00;
    end

    assign ptr_nxt = ptr + PW'(W);

    always_comb begin
        word = '0;
        for (int l = 0; l < W; l++) begin
            word[l*8+:8] = body_q[IW'(ptr + PW'(l))];
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (req_valid) state_d = req_type ? S_INIT : S_WAIT;
            S_WAIT:    if (unit_in_ready) state_d = S_HDR;
            S_HDR:     if (!unit_in_afull) state_d = S_BODY;
            S_BODY:    if (!unit_in_afull && ptr_nxt >= body_len) state_d = S_TRAILER;
            S_TRAILER,
            S_INIT:    if (!unit_in_afull) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= S_IDLE;
            ptr           <= '0;
            body_len      <= '0;
            body_q        <= '0;
            init_q        <= '0;
            unit_in       <= '0;
            unit_in_ctrl  <= 1'b0;
            unit_in_wr_en <= 1'b0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            req_ready     <= (state_d == S_IDLE);
            busy          <= (state_d != S_IDLE);
            // unit_in/ctrl keep their last value on stall cycles
            unit_in_wr_en <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    body_q   <= img;
                    body_len <= len_d;
                    init_q   <= init_data;
                    ptr      <= '0;
                end
                S_HDR, S_TRAILER: if (!unit_in_afull) begin
                    unit_in       <= '0;
                    unit_in_ctrl  <= 1'b1;
                    unit_in_wr_en <= 1'b1;
                end
                S_BODY: if (!unit_in_afull) begin
                    unit_in       <= word;
                    unit_in_ctrl  <= 1'b0;
                    unit_in_wr_en <= 1'b1;
                    ptr           <= ptr_nxt;
                end
                S_INIT: if (!unit_in_afull) begin
                    unit_in       <= OUT_WIDTH'({init_q, 3'b001});
                    unit_in_ctrl  <= 1'b1;
                    unit_in_wr_en <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/unit_pkt_serializer.md
# unit_pkt_serializer

Synthesizable, parametrised packet serializer that drives a sha512unit-style computing unit input (`unit_in`, `unit_in_ctrl`, `unit_in_wr_en`, `unit_in_afull`, `unit_in_ready`). It accepts one parallel packet descriptor at a time, either a data packet or an internal init packet, and emits the exact word stream the unit expects, with header and trailer framing and afull flow control. It sits between the arbiter and a unit, or drives a unit from a bench. Over a fixed byte-wide stream it adds configurable output width, configurable key capacity, and optional key trimming to 32-bit granularity.

## Interface
- OUT_WIDTH, 8: output word width in bits; legal values are 8, 16, 32. W = OUT_WIDTH/8 bytes per word.
- KEY_MAX_BYTES, 64: key capacity in bytes; must be a multiple of 4.
- KEY_TRIM, 0: 0 sends all KEY_MAX_BYTES key bytes; 1 sends key_len rounded up to a multiple of 4.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous, active-low reset
- req_valid  in  1  descriptor valid
- req_ready  out  1  high only in IDLE
- req_type  in  1  0 = data packet, 1 = init packet
- init_data  in  5  init payload (program select)
- cnt  in  32  round count
- salt_len  in  8  salt length
- salt  in  128  salt bytes; byte i at [i*8+:8]
- ids  in  64  packet IDs; byte i at [i*8+:8]
- key_len  in  8  key length in bytes
- key  in  KEY_MAX_BYTES*8  key bytes; byte i at [i*8+:8]
- unit_in  out  OUT_WIDTH  output word; byte 0 of the word in bits [7:0]
- unit_in_ctrl  out  1  framing word marker
- unit_in_wr_en  out  1  word write strobe
- unit_in_afull  in  1  unit input almost-full
- unit_in_ready  in  1  unit has an idle thread
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WAIT_READY, HDR, BODY, TRAILER, INIT.
- IDLE: req_ready=1. On req_valid, all descriptor fields are latched. Next state is INIT if req_type=1, else WAIT_READY.
- WAIT_READY: wait for unit_in_ready=1, then go to HDR.
- HDR: emit one word with ctrl=1 and data 0.
- BODY: payload byte sequence, packed W bytes per word, ctrl=0:
  - cnt bytes 0..3, little-endian
  - salt_len, then 3 zero bytes
  - salt bytes 0..15
  - ids bytes 0..7
  - key_len, then 7 zero bytes
  - K key bytes
- K: Kc = min(key_len, KEY_MAX_BYTES). K = KEY_MAX_BYTES if KEY_TRIM=0, else 4*ceil(Kc/4). If KEY_TRIM=1 and key_len=0, then K=0.
- Key bytes at index ≥ Kc are sent as 0x00 in both modes. The key_len field itself is always sent unclamped.
- Body length is (40+K)/W words. This is always an integer for legal parameters. A byte counter advances by W per emitted word; BODY ends when it reaches 40+K.
- TRAILER: emit one word with ctrl=1 and data 0, then return to IDLE.
- INIT: emit one word with ctrl=1 and unit_in = {init_data, 3'b001} zero-extended; no trailer. unit_in_ready is not checked; the issuer guarantees the unit is idle.

## Timing
- All outputs are registered. Reset values: unit_in=0, unit_in_ctrl=0, unit_in_wr_en=0, req_ready=1, busy=0; state is IDLE.
- Emitting states (HDR, BODY, TRAILER, INIT):
  - At an edge where unit_in_afull=0, the next word is registered with wr_en=1 and the pointer advances.
  - At an edge where unit_in_afull=1, wr_en=0 and the pointer holds; no word is dropped or duplicated.
  - unit_in and ctrl hold their last value while wr_en=0.
- Latency:
  - Data packet, unit ready and no afull: acceptance at edge N, WAIT_READY at N+1, header valid after edge N+2, then one word per cycle.
  - Init packet: word valid after edge N+1.
- Total data packet length is 2+(40+K)/W words. Examples: W=1, K=64 gives 106 words; W=4, K=64 gives 28 words.
- Only one packet is in flight. req_valid outside IDLE is ignored.
- unit_in_ready dropping after HDR has no effect on the rest of the packet.
- RESET_N asserted mid-packet: all outputs clear immediately (asynchronously) and the partial packet is abandoned. Recovery is upstream's responsibility.

## Test plan
- Init, OUT_WIDTH=8, init_data=1 -> exactly one word 0x09 with ctrl=1 and wr_en high for one cycle; busy returns to 0 one cycle later.
- Data packet, OUT_WIDTH=8, KEY_TRIM=0, cnt=16384, salt_len=8, salt="FURCPa.k", key_len=8, key="password", no afull -> 106 words.
  - Body starts 00 40 00 00 08 00 00 00 'F' ...
  - ids bytes are 0x0f.
  - The 56 key bytes after "password" are 00.
  - Header and trailer words have ctrl=1.
- Same packet with KEY_TRIM=1 -> 50 words; key section is exactly the 8 bytes "password".
- OUT_WIDTH=32, KEY_TRIM=1, key_len=5 -> K=8, 14 words; first body word 0x00004000; key bytes 5..7 are zero.
- unit_in_afull held high for 10 cycles mid-body, then toggled every cycle -> captured stream is identical to the no-afull run; wr_en is never high in a cycle after an edge where afull was high.
- unit_in_ready=0 for 50 cycles after acceptance -> no wr_en until ready rises. Then assert RESET_N low during BODY -> outputs are 0 immediately, req_ready=1 after release, and a following packet is emitted completely.
